// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - operand-pair accumulator built on a shared 3:2 carry-save adder
// Accumulates in_a+in_b per accepted beat and presents sum, sticky overflow flags and beat count.

module csa_accum_csa #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s
);
  logic [W-1:0] ps;
  logic [W-1:0] pc;
  logic [W:0]   cy;

  assign ps = a ^ b ^ c;
  assign pc = {((a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0])), 1'b0};

  // Ripple resolve of the saved sum/carry vectors; the final carry-out is dropped (mod 2^W).
  always_comb begin
    cy    = '0;
    s     = '0;
    for (int i = 0; i < W; i++) begin
      s[i]    = ps[i] ^ pc[i] ^ cy[i];
      cy[i+1] = (ps[i] & pc[i]) | (cy[i] & (ps[i] ^ pc[i]));
    end
  end
endmodule

module csa_accum_ctrl #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [size-1:0]  in_a,
  input  logic [size-1:0]  in_b,
  input  logic             in_last,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [size-1:0]  out_sum,
  output logic             out_uovf,
  output logic             out_sovf,
  output logic [CNT_W-1:0] out_beats
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [size-1:0]   acc_q;
  logic [size-1:0]   csa_s;
  logic              uovf_q;
  logic              sovf_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              clear;
  logic [size+1:0]   usum;
  logic [size+1:0]   ssum;
  logic              beat_uovf;
  logic              beat_sovf;

  csa_accum_csa #(.W(size)) u_csa (
    .a (acc_q),
    .b (in_a),
    .c (in_b),
    .s (csa_s)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready & ~abort;
  assign clear     = (out_valid & out_ready) | (in_ready & abort);

  // Overflow detection runs in a wider domain, independent of the CSA result.
  assign usum = {2'b00, acc_q} + {2'b00, in_a} + {2'b00, in_b};
  assign ssum = {{2{acc_q[size-1]}}, acc_q} + {{2{in_a[size-1]}}, in_a}
              + {{2{in_b[size-1]}}, in_b};
  assign beat_uovf = |usum[size+1:size];
  assign beat_sovf = ~((ssum[size+1:size-1] == 3'b000) | (ssum[size+1:size-1] == 3'b111));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (abort)       state_d = IDLE;
        else if (accept) state_d = in_last ? DONE : ACCUM;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      uovf_q <= 1'b0;
      sovf_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      uovf_q <= 1'b0;
      sovf_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      acc_q  <= csa_s;
      uovf_q <= uovf_q | beat_uovf;
      sovf_q <= sovf_q | beat_sovf;
      cnt_q  <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  assign out_sum   = acc_q;
  assign out_uovf  = uovf_q;
  assign out_sovf  = sovf_q;
  assign out_beats = cnt_q;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - directed self-checking bench for csa_accum_ctrl
// Two instances: 8-bit with 8-bit counter, and 8-bit with 2-bit counter for saturation.

module tb_csa_accum_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready, out_valid, out_uovf, out_sovf;
  logic [7:0] out_sum, out_beats;

  logic       s_in_valid = 1'b0, s_in_last = 1'b0, s_abort = 1'b0, s_out_ready = 1'b0;
  logic [7:0] s_in_a = '0, s_in_b = '0;
  logic       s_in_ready, s_out_valid, s_out_uovf, s_out_sovf;
  logic [7:0] s_out_sum;
  logic [1:0] s_out_beats;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csa_accum_ctrl #(.size(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_uovf(out_uovf), .out_sovf(out_sovf), .out_beats(out_beats)
  );

  csa_accum_ctrl #(.size(8), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last), .abort(s_abort),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
    .out_uovf(s_out_uovf), .out_sovf(s_out_sovf), .out_beats(s_out_beats)
  );

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({out_sum, out_uovf, out_sovf, out_beats} !== 18'h0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b/%h exp=0", out_sum, out_uovf, out_sovf, out_beats); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_beat();
    send(8'd3, 8'd4, 1'b0);
    total++; if (out_valid !== 1'b0 || out_sum !== 8'h07) begin bad++; $display("FAIL two_beat_mid got=v%b s%h exp=v0 s07", out_valid, out_sum); end
    send(8'd5, 8'd6, 1'b1);
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL two_beat_valid got=v%b r%b exp=v1 r0", out_valid, in_ready); end
    total++; if (out_sum !== 8'h12) begin bad++; $display("FAIL two_beat_sum got=%h exp=12", out_sum); end
    total++; if ({out_uovf, out_sovf} !== 2'b00) begin bad++; $display("FAIL two_beat_flags got=%b%b exp=00", out_uovf, out_sovf); end
    total++; if (out_beats !== 8'd2) begin bad++; $display("FAIL two_beat_beats got=%0d exp=2", out_beats); end
    handshake();
  endtask

  task automatic test_backpressure();
    send(8'hFF, 8'hFF, 1'b1);
    total++; if (out_sum !== 8'hFE || out_uovf !== 1'b1 || out_sovf !== 1'b0 || out_beats !== 8'd1) begin bad++; $display("FAIL single_beat got=%h u%b s%b n%0d exp=fe u1 s0 n1", out_sum, out_uovf, out_sovf, out_beats); end
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 0); in_a = 8'h11; in_b = 8'h22;
      abort = (i == 1);
      @(posedge clk); #1;
      in_valid = 1'b0; abort = 1'b0;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'hFE || out_uovf !== 1'b1 || out_sovf !== 1'b0 || out_beats !== 8'd1) begin
        bad++; $display("FAIL hold_cycle%0d got=v%b r%b %h u%b s%b n%0d exp=v1 r0 fe u1 s0 n1", i, out_valid, in_ready, out_sum, out_uovf, out_sovf, out_beats);
      end
    end
    handshake();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h00 || out_beats !== 8'd0 || out_uovf !== 1'b0) begin bad++; $display("FAIL after_handshake got=r%b v%b %h n%0d u%b exp=r1 v0 00 n0 u0", in_ready, out_valid, out_sum, out_beats, out_uovf); end
  endtask

  task automatic test_back_to_back();
    send(8'd1, 8'd1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h02 || out_beats !== 8'd1 || out_uovf !== 1'b0) begin bad++; $display("FAIL back_to_back got=v%b %h n%0d u%b exp=v1 02 n1 u0", out_valid, out_sum, out_beats, out_uovf); end
    handshake();
  endtask

  task automatic test_sticky();
    send(8'h7F, 8'h01, 1'b0);
    total++; if (out_sum !== 8'h80 || out_sovf !== 1'b1 || out_uovf !== 1'b0) begin bad++; $display("FAIL sticky_step1 got=%h u%b s%b exp=80 u0 s1", out_sum, out_uovf, out_sovf); end
    send(8'h80, 8'h00, 1'b1);
    total++; if (out_sum !== 8'h00 || out_uovf !== 1'b1 || out_sovf !== 1'b1 || out_beats !== 8'd2) begin bad++; $display("FAIL sticky_final got=%h u%b s%b n%0d exp=00 u1 s1 n2", out_sum, out_uovf, out_sovf, out_beats); end
    handshake();
  endtask

  task automatic test_async_reset();
    send(8'd10, 8'd20, 1'b0);
    total++; if (out_sum !== 8'd30 || out_beats !== 8'd1) begin bad++; $display("FAIL pre_reset got=%0d n%0d exp=30 n1", out_sum, out_beats); end
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_beats !== 8'd0 || out_sum !== 8'd0) begin bad++; $display("FAIL async_reset got=v%b r%b n%0d %h exp=v0 r1 n0 00", out_valid, in_ready, out_beats, out_sum); end
    #2 reset = 1'b0;
    send(8'd1, 8'd2, 1'b1);
    total++; if (out_valid !== 1'b1 || out_sum !== 8'h03 || out_beats !== 8'd1) begin bad++; $display("FAIL post_reset_sum got=v%b %h n%0d exp=v1 03 n1", out_valid, out_sum, out_beats); end
    handshake();
  endtask

  task automatic test_abort();
    send(8'd10, 8'd20, 1'b0);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0 || out_beats !== 8'd0) begin bad++; $display("FAIL abort_clear got=v%b r%b %h n%0d exp=v0 r1 00 n0", out_valid, in_ready, out_sum, out_beats); end
    send(8'd1, 8'd2, 1'b1);
    total++; if (out_sum !== 8'h03 || out_beats !== 8'd1) begin bad++; $display("FAIL post_abort_sum got=%h n%0d exp=03 n1", out_sum, out_beats); end
    handshake();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_a = 8'd1; s_in_b = 8'd0; s_in_last = (i == 4);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    total++; if (s_out_valid !== 1'b1 || s_out_beats !== 2'd3 || s_out_sum !== 8'h05) begin bad++; $display("FAIL saturation got=v%b n%0d %h exp=v1 n3 05", s_out_valid, s_out_beats, s_out_sum); end
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_async_reset();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
